fwd_ctrl: RTL and testbench

FWD_CTRL -- requirements
Module: fwd_ctrl

---
 rtl/fwd_ctrl.sv | 135 +++++++++++++
 tb/tb_fwd_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-1 forwarding and issue control for a short in-order pipe.
// Tracks the EX, MEM and WB instructions and decides, in the same cycle,
// whether the decode instruction may issue and whether operand 1 takes the
// EX result (alu_output) instead of the register file.
// Optional feature macro: FWD_PERF_CNT_EN adds saturating stall/forward
// counters (stall_cnt, fwd_cnt). The default build has no counters.
// Handshake: decode offers an instruction with id_valid; it is accepted
// (issue=1) on an edge where stall=0. While stall=1 decode keeps it.
module fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_use_pc,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  input  logic        id_is_load,
  input  logic        hold,
  input  logic        flush,
  output logic        mux1_s,
  output logic        mux1_redir,
  output logic        stall,
  output logic        issue,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] fwd_cnt,
`endif
  output logic        dbg_state_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } slot_t;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  slot_t  ex_q, mem_q, wb_q;
  slot_t  ex_d, mem_d, wb_d;
  state_t state_q, state_d;

  logic src_ok;
  logic ex_hit, mem_hit, wb_hit;
  logic dep_stall;

  // Hazard detection; the youngest producer (EX) decides when it matches.
  always_comb begin
    src_ok    = (id_rs1 != 5'd0) & ~id_use_pc;
    ex_hit    = src_ok & ex_q.valid  & ex_q.wen  & (ex_q.rd  == id_rs1);
    mem_hit   = src_ok & mem_q.valid & mem_q.wen & (mem_q.rd == id_rs1);
    wb_hit    = src_ok & wb_q.valid  & wb_q.wen  & (wb_q.rd  == id_rs1);
    dep_stall = ex_hit ? ex_q.load : (mem_hit | wb_hit);
    stall     = id_valid & (dep_stall | hold);
    issue     = id_valid & ~stall;
    mux1_redir = id_valid & ex_hit & ~ex_q.load & ~stall;
    mux1_s    = id_valid & id_use_pc;
  end

  // Slot advance: shift on a free edge, freeze under hold; flush kills EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (hold) begin
      if (flush) ex_d.valid = 1'b0;
    end else begin
      wb_d        = mem_q;
      mem_d       = ex_q;
      mem_d.valid = ex_q.valid & ~flush;
      ex_d.valid  = issue;
      ex_d.wen    = id_wen & (id_rd != 5'd0);
      ex_d.rd     = ex_d.wen ? id_rd : 5'd0;
      ex_d.load   = id_is_load;
    end
  end

  // FSM next state: BUBBLE while decode is stalled, frozen under hold.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        RUN:     if (stall)  state_d = BUBBLE;
        BUBBLE:  if (!stall) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State registers; reset wins over hold and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

  assign dbg_state_o = state_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters for stall cycles and forward cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))    stall_cnt_d = stall_cnt_q + 32'd1;
    if (mux1_redir && (fwd_cnt_q != 32'hFFFF_FFFF)) fwd_cnt_d   = fwd_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_fwd_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_use_pc;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic        id_is_load;
  logic        hold;
  logic        flush;
  logic        mux1_s;
  logic        mux1_redir;
  logic        stall;
  logic        issue;
  logic        dbg_state_o;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  int passed = 0;
  int total  = 0;

  fwd_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_use_pc(id_use_pc), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .mux1_s(mux1_s), .mux1_redir(mux1_redir), .stall(stall), .issue(issue),
`ifdef FWD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    int rd;
    bit wen;
    bit ld;
  } mslot_t;

  mslot_t      m[3];          // index 0 = EX (youngest), 1 = MEM, 2 = WB
  bit          m_bubble;      // decode was stalled at the last free edge
  bit          chk_en = 0;
  logic [31:0] m_stall_cnt, m_fwd_cnt;

  // Expected outputs: find the youngest in-flight writer of rs1.
  function automatic void model_out(output bit e_s, output bit e_redir,
                                    output bit e_stall, output bit e_issue);
    int  who;
    bit  dep;
    who = -1;
    if (id_rs1 != 0 && !id_use_pc)
      for (int i = 2; i >= 0; i--)
        if (m[i].v && m[i].wen && m[i].rd == int'(id_rs1)) who = i;
    if (who < 0)       dep = 0;
    else if (who == 0) dep = m[0].ld;
    else               dep = 1;
    e_stall = id_valid && (dep || hold);
    e_issue = id_valid && !e_stall;
    e_redir = id_valid && who == 0 && !m[0].ld && !e_stall;
    e_s     = id_valid && id_use_pc;
  endfunction

  // Model advance at each rising edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    bit e_s, e_redir, e_stall, e_issue;
    model_out(e_s, e_redir, e_stall, e_issue);
    if (rst) begin
      for (int i = 0; i < 3; i++) m[i].v = 0;
      m_bubble    = 0;
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
      chk_en      = 1;
    end else begin
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e_redir && m_fwd_cnt != 32'hFFFF_FFFF)   m_fwd_cnt++;
      if (hold) begin
        if (flush) m[0].v = 0;
      end else begin
        m[2]     = m[1];
        m[1]     = m[0];
        if (flush) m[1].v = 0;
        m[0].v   = e_issue;
        m[0].rd  = int'(id_rd);
        m[0].wen = id_wen && id_rd != 0;
        m[0].ld  = id_is_load;
        m_bubble = e_stall;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit e_s, e_redir, e_stall, e_issue;
    if (chk_en) begin
      model_out(e_s, e_redir, e_stall, e_issue);
      chk("m_mux1_s", {31'd0, mux1_s}, {31'd0, e_s});
      chk("m_redir",  {31'd0, mux1_redir}, {31'd0, e_redir});
      chk("m_stall",  {31'd0, stall}, {31'd0, e_stall});
      chk("m_issue",  {31'd0, issue}, {31'd0, e_issue});
      chk("m_state",  {31'd0, dbg_state_o}, {31'd0, m_bubble});
`ifdef FWD_PERF_CNT_EN
      chk("m_stall_cnt", stall_cnt, m_stall_cnt);
      chk("m_fwd_cnt",   fwd_cnt,   m_fwd_cnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit pc,
                        input int rd, input bit wen, input bit ld);
    id_valid   = v;
    id_rs1     = 5'(rs1);
    id_use_pc  = pc;
    id_rd      = 5'(rd);
    id_wen     = wen;
    id_is_load = ld;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0);
    hold  = 0;
    flush = 0;
    repeat (3) cyc();
  endtask

  // Sample the DUT at the next falling edge for directed literal checks.
  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    hold = 0;
    flush = 0;
    set_id(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst = 0;

    // Cycle after reset with nothing offered.
    at_neg();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_mux1_s", {31'd0, mux1_s}, 32'd0);
    chk("rst_redir", {31'd0, mux1_redir}, 32'd0);
    chk("rst_state", {31'd0, dbg_state_o}, 32'd0);
    cyc();

    // EX forward: add rd=5, then a consumer of r5.
    set_id(1, 0, 0, 5, 1, 0);
    at_neg();
    chk("fwd_prod_issue", {31'd0, issue}, 32'd1);
    cyc();
    set_id(1, 5, 0, 0, 0, 0);
    at_neg();
    chk("fwd_redir", {31'd0, mux1_redir}, 32'd1);
    chk("fwd_stall", {31'd0, stall}, 32'd0);
    chk("fwd_issue", {31'd0, issue}, 32'd1);
    cyc();

    // Load-use: three stall cycles, then issue without forward.
    drain();
    set_id(1, 0, 0, 7, 1, 1);
    cyc();
    set_id(1, 7, 0, 0, 0, 0);
    at_neg();
    chk("lu_stall1", {31'd0, stall}, 32'd1);
    chk("lu_state1", {31'd0, dbg_state_o}, 32'd0);
    cyc();
    at_neg();
    chk("lu_stall2", {31'd0, stall}, 32'd1);
    chk("lu_state2", {31'd0, dbg_state_o}, 32'd1);
    cyc();
    at_neg();
    chk("lu_stall3", {31'd0, stall}, 32'd1);
    chk("lu_state3", {31'd0, dbg_state_o}, 32'd1);
    cyc();
    at_neg();
    chk("lu_stall4", {31'd0, stall}, 32'd0);
    chk("lu_issue4", {31'd0, issue}, 32'd1);
    chk("lu_redir4", {31'd0, mux1_redir}, 32'd0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0);
    at_neg();
    chk("lu_state5", {31'd0, dbg_state_o}, 32'd0);
    cyc();

    // r0 producer and consumer: never a hazard.
    drain();
    set_id(1, 0, 0, 0, 1, 0);
    cyc();
    set_id(1, 0, 0, 0, 0, 0);
    at_neg();
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_redir", {31'd0, mux1_redir}, 32'd0);
    cyc();
    // PC operand with a matching rs1 in EX.
    set_id(1, 0, 0, 9, 1, 0);
    cyc();
    set_id(1, 9, 1, 0, 0, 0);
    at_neg();
    chk("pc_mux1_s", {31'd0, mux1_s}, 32'd1);
    chk("pc_redir", {31'd0, mux1_redir}, 32'd0);
    chk("pc_stall", {31'd0, stall}, 32'd0);
    cyc();

    // Flush kills the producer in EX.
    drain();
    set_id(1, 0, 0, 3, 1, 0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0);
    flush = 1;
    cyc();
    flush = 0;
    set_id(1, 3, 0, 0, 0, 0);
    at_neg();
    chk("fl_redir", {31'd0, mux1_redir}, 32'd0);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_issue", {31'd0, issue}, 32'd1);
    cyc();

    // Hold with a MEM hit, then reset in the middle of the stall.
    drain();
    set_id(1, 0, 0, 4, 1, 0);
    cyc();
    set_id(0, 0, 0, 0, 0, 0);
    cyc();
    set_id(1, 4, 0, 0, 0, 0);
    hold = 1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("hold_stall", {31'd0, stall}, 32'd1);
      chk("hold_issue", {31'd0, issue}, 32'd0);
      cyc();
    end
    hold = 0;
    at_neg();
    chk("hold_kept_mem", {31'd0, stall}, 32'd1);
    cyc();
    rst = 1;
    at_neg();
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    cyc();
    rst = 0;
    at_neg();
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_issue", {31'd0, issue}, 32'd1);
`ifdef FWD_PERF_CNT_EN
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_fwd_cnt", fwd_cnt, 32'd0);
`endif
    cyc();

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 0;
    set_id(0, 0, 0, 0, 0, 0);
    at_neg();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
